// File: rtl/scope_capture.sv
// scope_capture: channel select, 8-bit reduction, edge trigger and circular record capture.
// Optional forced trigger after TIMEOUT_SAMPLES armed samples when TRIG_TIMEOUT_EN is defined.
module scope_capture #(
  parameter int DEPTH_LOG2      = 9,
  parameter int PRETRIG         = 64,
  parameter int TIMEOUT_SAMPLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           adc_word,
  input  logic                  sample_stb,
  input  logic                  ch_sel,
  input  logic                  arm,
  input  logic [7:0]            trig_level,
  input  logic                  trig_falling,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [7:0]            rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  forced
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PRE_CNT  = DEPTH_LOG2'(PRETRIG);
  localparam logic [DEPTH_LOG2-1:0] POST_CNT = DEPTH_LOG2'(DEPTH - PRETRIG - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREFILL = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_POST    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  if (PRETRIG < 1 || PRETRIG > DEPTH - 2) begin : g_bad_pretrig
    $error("scope_capture: PRETRIG out of range");
  end
  if (TIMEOUT_SAMPLES < 1) begin : g_bad_timeout
    $error("scope_capture: TIMEOUT_SAMPLES must be at least 1");
  end

  logic [2:0]            state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] start_ptr;
  logic [DEPTH_LOG2-1:0] cnt;
  logic [DEPTH_LOG2-1:0] cnt_inc;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic signed [7:0]     s_p0;
  logic signed [7:0]     prev_s;
  logic signed [7:0]     level;
  logic                  wr_en;
  logic                  hit;
  logic                  timeout;
  logic                  unused_bits;
  logic signed [7:0]     mem [DEPTH];

  // Arithmetic truncation: keep the top 8 bits of the 14-bit two's complement value.
  function automatic logic signed [7:0] trunc_sample(input logic [13:0] v);
    return signed'(v[13:6]);
  endfunction

  // Stage p0: channel select and reduction, consumed on the strobe cycle.
  assign s_p0        = ch_sel ? trunc_sample(adc_word[13:0]) : trunc_sample(adc_word[29:16]);
  assign unused_bits = ^{adc_word[31:30], adc_word[15:14]};
  assign level       = signed'(trig_level);
  assign wr_en       = sample_stb & busy;
  assign cnt_inc     = cnt + 1'b1;
  assign rd_idx      = start_ptr + rd_addr;

  always_comb begin
    if (trig_falling) hit = (prev_s > level) && (s_p0 <= level);
    else              hit = (prev_s < level) && (s_p0 >= level);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s_p0;
      prev_s      <= s_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= mem[rd_idx];
  end

`ifdef TRIG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_SAMPLES + 1);
  logic [TO_W-1:0] tcnt;
  logic [TO_W-1:0] tcnt_inc;

  assign tcnt_inc = tcnt + 1'b1;
  assign timeout  = (state == S_ARMED) && (tcnt_inc == TO_W'(TIMEOUT_SAMPLES));

  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt   <= '0;
      forced <= 1'b0;
    end else begin
      if (state != S_ARMED) tcnt <= '0;
      else if (wr_en)       tcnt <= tcnt_inc;
      // A real edge on the timeout write wins, leaving forced clear.
      if ((state == S_IDLE || state == S_DONE) && arm) forced <= 1'b0;
      else if (wr_en && !hit && timeout)               forced <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign forced  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      start_ptr <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state <= S_PREFILL;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        S_PREFILL: begin
          if (wr_en) begin
            cnt <= cnt_inc;
            if (cnt_inc == PRE_CNT) begin
              state <= S_ARMED;
              cnt   <= '0;
            end
          end
        end
        S_ARMED: begin
          if (wr_en && (hit || timeout)) begin
            state     <= S_POST;
            cnt       <= '0;
            start_ptr <= wr_ptr - PRE_CNT;
          end
        end
        S_POST: begin
          if (wr_en) begin
            cnt <= cnt_inc;
            if (cnt_inc == POST_CNT) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: directed captures with table-driven readback checks against hand-computed records.
module tb_scope_capture;
  localparam int DL  = 9;
  localparam int TO  = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   adc_word;
  logic          sample_stb;
  logic          ch_sel;
  logic          arm;
  logic [7:0]    trig_level;
  logic          trig_falling;
  logic [DL-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          done;
  logic          forced;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int addr; int exp; } rd_vec_t;
  rd_vec_t tbl[$];

  always #5 clk = ~clk;

  scope_capture #(.DEPTH_LOG2(DL), .PRETRIG(64), .TIMEOUT_SAMPLES(TO)) dut (
    .clk(clk), .rst(rst), .adc_word(adc_word), .sample_stb(sample_stb), .ch_sel(ch_sel),
    .arm(arm), .trig_level(trig_level), .trig_falling(trig_falling), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .forced(forced)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int a, input int e);
    tbl.push_back('{a, e});
  endfunction

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      rd_addr = DL'(tbl[i].addr);
      tick(1);
      check($sformatf("%s rd[%0d]", tag, tbl[i].addr), $signed(rd_data), tbl[i].exp);
    end
  endtask

  // One strobe carrying v on channel ch; the other channel holds unrelated data.
  task automatic send(input int v, input logic ch, input int gap);
    logic [7:0] b;
    b = v[7:0];
    if (ch) adc_word = {2'b00, 14'h0000, 2'b00, b, 6'h2A};
    else    adc_word = {2'b11, b, 6'h15, 2'b11, ~b, 6'h3F};
    ch_sel     = ch;
    sample_stb = 1'b1;
    tick(1);
    sample_stb = 1'b0;
    adc_word   = $urandom;
    ch_sel     = ~ch;
    if (gap > 1) tick(gap - 1);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  function automatic int wrap8(input int v);
    int r;
    r = v & 255;
    return (r > 127) ? r - 256 : r;
  endfunction

  task automatic run_square(input bit disturb, input string tag);
    int k;
    k = 0;
    trig_level   = 8'hF6;
    trig_falling = 1'b1;
    pulse_arm();
    check({tag, " busy after arm"}, busy, 1);
    while (!done && k < 2000) begin
      send((((k / 8) % 2) == 0) ? 100 : -100, 1'b1, 4);
      if (disturb && busy) pulse_arm();
      k++;
    end
    check({tag, " done"}, done, 1);
    check({tag, " samples to done"}, k, 520);
    check({tag, " forced"}, forced, 0);
    tbl.delete();
    add(63, 100); add(64, -100); add(56, 100); add(55, -100);
    add(72, 100); add(71, -100); add(0, -100); add(511, 100);
    run_table(tag);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b0; sample_stb = 1'b0; arm = 1'b0; ch_sel = 1'b0; adc_word = '0;
    trig_level = '0; trig_falling = 1'b0; rd_addr = '0;
    tick(3);
    check("por busy", busy, 0);
    check("por done", done, 0);
    check("por forced", forced, 0);
    check("por rd_data", $signed(rd_data), 0);
    rst = 1'b1;
    tick(2);

    run_square(1'b0, "fall");

    // Re-arm from DONE, then reset in the middle of POST.
    pulse_arm();
    check("rearm done drop", done, 0);
    check("rearm busy", busy, 1);
    trig_level = 8'd40; trig_falling = 1'b0;
    for (int i = 0; i < 64; i++) send(30, 1'b0, 3);
    send(10, 1'b0, 3);
    send(50, 1'b0, 3);
    for (int i = 0; i < 10; i++) send(20, 1'b0, 3);
    check("post busy", busy, 1);
    check("post done", done, 0);
    rst = 1'b0;
    tick(3);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort forced", forced, 0);
    check("abort rd_data", $signed(rd_data), 0);
    rst = 1'b1;
    tbl.delete();
    add(0, 100); add(72, 10); add(73, 50); add(8, 30);
    run_table("ram kept");
    send(-7, 1'b0, 3);
    tbl.delete();
    add(0, 100); add(1, 100);
    run_table("idle no write");
    check("idle busy", busy, 0);

    run_square(1'b1, "arm disturb");

    // Ramp on channel 0 with rising trigger at 0.
    pulse_arm();
    trig_level = 8'd0; trig_falling = 1'b0;
    k = 0;
    while (!done && k < 2000) begin
      send(wrap8(k - 128), 1'b0, 34);
      k++;
    end
    check("ramp done", done, 1);
    check("ramp samples to done", k, 576);
    tbl.delete();
    add(64, 0); add(0, -64); add(63, -1); add(65, 1);
    add(191, 127); add(192, -128); add(300, -20); add(511, -65);
    run_table("ramp");

    // Wrap: a long untriggered stretch pushes the record across the end of the RAM.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    pulse_arm();
    for (int i = 0; i < 500; i++) send(-50, 1'b0, 3);
    check("wrap still busy", busy, 1);
    k = 0;
    while (!done && k < 2000) begin
      send(wrap8(k - 50), 1'b0, 3);
      k++;
    end
    check("wrap done", done, 1);
    check("wrap samples to done", k, 498);
    tbl.delete();
    add(0, -50); add(13, -50); add(14, -50); add(15, -49); add(30, -34);
    add(63, -1); add(64, 0); add(100, 36); add(191, 127); add(192, -128); add(511, -65);
    run_table("wrap");

    trig_level = 8'd50; trig_falling = 1'b0;
`ifdef TRIG_TIMEOUT_EN
    pulse_arm();
    k = 0;
    while (!done && k < 3000) begin
      send(5, 1'b0, 3);
      k++;
    end
    check("timeout done", done, 1);
    check("timeout samples to done", k, 64 + TO + 447);
    check("timeout forced", forced, 1);
    tbl.delete();
    add(64, 5); add(0, 5); add(511, 5);
    run_table("timeout");

    pulse_arm();
    check("rearm forced clear", forced, 0);
    k = 0;
    while (!done && k < 3000) begin
      send((k == 63 + TO) ? 60 : 5, 1'b0, 3);
      k++;
    end
    check("edge vs timeout done", done, 1);
    check("edge vs timeout samples", k, 64 + TO + 447);
    check("edge vs timeout forced", forced, 0);
    tbl.delete();
    add(64, 60); add(63, 5); add(65, 5);
    run_table("edge vs timeout");
`else
    pulse_arm();
    for (int i = 0; i < 1600; i++) send(5, 1'b0, 3);
    check("no timeout busy", busy, 1);
    check("no timeout done", done, 0);
    check("no timeout forced", forced, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
